// File: rtl/hf_subcarrier_demod_if.sv
// hf_subcarrier_demod_if: sample/control inputs and detector/SSP outputs of the subcarrier demodulator
interface hf_subcarrier_demod_if #(
  parameter int ADC_W = 8,
  parameter int SUBC_LOG2 = 4,
  parameter int CNT_W = 16
);
  logic enable;
  logic [ADC_W-1:0] adc_d;
  logic [ADC_W+1:0] threshold;
  logic [SUBC_LOG2-1:0] reset_phase;
  logic clear_count;
  logic curbit;
  logic curbit_valid;
  logic [CNT_W-1:0] mod_count;
  logic ssp_clk;
  logic ssp_frame;
  logic ssp_din;
  modport master(
    output enable, adc_d, threshold, reset_phase, clear_count,
    input curbit, curbit_valid, mod_count, ssp_clk, ssp_frame, ssp_din
  );
  modport slave(
    input enable, adc_d, threshold, reset_phase, clear_count,
    output curbit, curbit_valid, mod_count, ssp_clk, ssp_frame, ssp_din
  );
endinterface

// File: rtl/hf_subcarrier_demod.sv
// hf_subcarrier_demod: derivative-filter subcarrier detector with per-window decision serialised over SSP
module hf_subcarrier_demod #(
  parameter int ADC_W = 8,
  parameter int SUBC_LOG2 = 4,
  parameter int FRAME_BITS = 8,
  parameter int CNT_W = 16
) (
  input logic osc_clk,
  input logic rst,
  hf_subcarrier_demod_if.slave bus
);
  localparam int P = 1 << SUBC_LOG2;
  localparam int CW = SUBC_LOG2 + $clog2(FRAME_BITS);
  localparam int FW = ADC_W + 3;
  logic [CW-1:0] cnt;
  logic [SUBC_LOG2-1:0] lo;
  logic [ADC_W-1:0] p1, p2, p3, p4;
  logic [FW-1:0] pos, neg;
  logic signed [FW-1:0] f, fall_max, rise_min, thr;
  logic boundary, hit;
  assign lo = cnt[SUBC_LOG2-1:0];
  assign pos = {2'b0, p4, 1'b0} + {3'b0, p3};
  assign neg = {2'b0, bus.adc_d, 1'b0} + {3'b0, p1};
  assign f = $signed(pos - neg);
  assign thr = $signed({1'b0, bus.threshold});
  assign boundary = lo == bus.reset_phase;
  assign hit = fall_max > thr && rise_min < -thr;
  always_ff @(negedge osc_clk or posedge rst)
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      p4 <= '0;
    end else begin
      p1 <= bus.adc_d;
      p2 <= p1;
      p3 <= p2;
      p4 <= p3;
    end
  // peaks start at 0, so any f beating them already has the right sign
  always_ff @(negedge osc_clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      fall_max <= '0;
      rise_min <= '0;
      bus.curbit <= 1'b0;
      bus.curbit_valid <= 1'b0;
    end else if (!bus.enable) begin
      cnt <= '0;
      fall_max <= '0;
      rise_min <= '0;
      bus.curbit <= 1'b0;
      bus.curbit_valid <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      bus.curbit_valid <= boundary;
      if (boundary) begin
        bus.curbit <= hit;
        fall_max <= '0;
        rise_min <= '0;
      end else begin
        if (f > fall_max) fall_max <= f;
        if (f < rise_min) rise_min <= f;
      end
    end
  always_ff @(negedge osc_clk or posedge rst)
    if (rst) bus.mod_count <= '0;
    else if (bus.clear_count) bus.mod_count <= '0;
    else if (bus.enable && boundary && hit && !(&bus.mod_count)) bus.mod_count <= bus.mod_count + 1'b1;
  always_ff @(negedge osc_clk or posedge rst)
    if (rst) begin
      bus.ssp_clk <= 1'b0;
      bus.ssp_frame <= 1'b0;
      bus.ssp_din <= 1'b0;
    end else if (!bus.enable) begin
      bus.ssp_clk <= 1'b0;
      bus.ssp_frame <= 1'b0;
      bus.ssp_din <= 1'b0;
    end else begin
      if (lo == '0) begin
        bus.ssp_clk <= 1'b1;
        bus.ssp_din <= bus.curbit;
      end else if (lo == SUBC_LOG2'(P / 2)) begin
        bus.ssp_clk <= 1'b0;
      end
      if (cnt == CW'(P / 2 - 1)) bus.ssp_frame <= 1'b1;
      else if (cnt == CW'(P + P / 2 - 1)) bus.ssp_frame <= 1'b0;
    end
endmodule

// File: tb/tb_hf_subcarrier_demod.sv
// tb_hf_subcarrier_demod: vector table, hand sequences and random stimulus against a window-list model
module tb_hf_subcarrier_demod;
  localparam int P = 16;
  localparam int N = 128;
  localparam int CNT_MAX = 15;
  logic osc_clk = 1'b0;
  logic rst = 1'b1;
  hf_subcarrier_demod_if #(.ADC_W(8), .SUBC_LOG2(4), .CNT_W(4)) bus();
  hf_subcarrier_demod #(.ADC_W(8), .SUBC_LOG2(4), .FRAME_BITS(8), .CNT_W(4)) dut (
    .osc_clk(osc_clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 osc_clk = ~osc_clk;
  int n_checks = 0;
  int n_fail = 0;
  int thr = 40;
  int rph = 3;
  int hist[4];
  int phase;
  int win_f[$];
  bit e_cur, e_val, e_sclk, e_frame, e_din;
  int e_cnt;
  typedef struct {int lo_v; int hi_v; int th; int exp_cur;} vec_t;
  vec_t vecs[10];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    foreach (hist[i]) hist[i] = 0;
    phase = 0;
    win_f.delete();
    {e_cur, e_val, e_sclk, e_frame, e_din} = '0;
    e_cnt = 0;
  endfunction
  function automatic void model_edge(input bit en, input int adc, input bit clr);
    int f, fmax, rmin, lo;
    bit prev, dec;
    prev = e_cur;
    f = 2 * hist[3] + hist[2] - 2 * adc - hist[0];
    if (clr) e_cnt = 0;
    if (!en) begin
      phase = 0;
      win_f.delete();
      {e_cur, e_val, e_sclk, e_frame, e_din} = '0;
    end else begin
      lo = phase % P;
      if (lo == rph) begin
        fmax = 0;
        rmin = 0;
        foreach (win_f[i]) begin
          if (win_f[i] > fmax) fmax = win_f[i];
          if (win_f[i] < rmin) rmin = win_f[i];
        end
        dec = fmax > thr && rmin < -thr;
        if (!clr && dec && e_cnt < CNT_MAX) e_cnt++;
        e_cur = dec;
        e_val = 1;
        win_f.delete();
      end else begin
        e_val = 0;
        win_f.push_back(f);
      end
      if (lo == 0) begin
        e_sclk = 1;
        e_din = prev;
      end else if (lo == P / 2) e_sclk = 0;
      if (phase == P / 2 - 1) e_frame = 1;
      else if (phase == P + P / 2 - 1) e_frame = 0;
      phase = (phase + 1) % N;
    end
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = adc;
  endfunction
  task automatic step(input bit en, input int adc, input bit clr);
    bus.enable = en;
    bus.adc_d = 8'(adc);
    bus.clear_count = clr;
    bus.threshold = 10'(thr);
    bus.reset_phase = 4'(rph);
    model_edge(en, adc, clr);
    @(posedge osc_clk);
    #1;
    check("outputs", {bus.curbit, bus.curbit_valid, bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.mod_count},
          {e_cur, e_val, e_sclk, e_frame, e_din, 4'(e_cnt)});
  endtask
  function automatic int sq(input int i, input int lo_v, input int hi_v);
    return ((i / 8) % 2) ? hi_v : lo_v;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt_a, cnt_b, held, sq_i, edges;
    bit seen;
    vecs[0] = '{100, 200, 40, 1};
    vecs[1] = '{100, 110, 30, 0};
    vecs[2] = '{100, 110, 29, 1};
    vecs[3] = '{100, 100, 0, 0};
    vecs[4] = '{100, 200, 299, 1};
    vecs[5] = '{100, 200, 300, 0};
    vecs[6] = '{0, 255, 764, 1};
    vecs[7] = '{0, 255, 765, 0};
    vecs[8] = '{50, 51, 2, 1};
    vecs[9] = '{50, 51, 3, 0};
    bus.enable = 0;
    bus.adc_d = 0;
    bus.clear_count = 0;
    bus.threshold = 10'(thr);
    bus.reset_phase = 4'(rph);
    model_reset();
    #12;
    check("reset_outputs", {bus.curbit, bus.curbit_valid, bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.mod_count}, 0);
    @(posedge osc_clk);
    #1;
    rst = 0;
    // idle: flat input, pulses at lo==3, one frame marker per 128 edges
    cnt_a = 0;
    cnt_b = 0;
    held = 0;
    for (int i = 0; i < N; i++) begin
      seen = bus.ssp_frame;
      step(1, 100, 0);
      if (bus.curbit_valid) cnt_a++;
      if (bus.ssp_frame && !seen) cnt_b++;
      if (bus.curbit) held++;
    end
    check("idle_valid_pulses", cnt_a, 8);
    check("idle_frame_rises", cnt_b, 1);
    check("idle_curbit_highs", held, 0);
    check("idle_mod_count", bus.mod_count, 0);
    // continuous modulation drives the 4-bit counter into saturation
    sq_i = 0;
    for (int i = 0; i < 20 * P; i++) begin
      step(1, sq(sq_i, 100, 200), 0);
      sq_i++;
    end
    check("mod_curbit", bus.curbit, 1);
    check("mod_ssp_din", bus.ssp_din, 1);
    check("mod_saturated", bus.mod_count, CNT_MAX);
    for (int i = 0; i < 40 && (phase % P) != rph; i++) begin
      step(1, sq(sq_i, 100, 200), 0);
      sq_i++;
    end
    step(1, sq(sq_i, 100, 200), 1);
    sq_i++;
    check("clear_with_pulse_valid", bus.curbit_valid, 1);
    check("clear_with_pulse_count", bus.mod_count, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1, sq(sq_i, 100, 200), 0);
      sq_i++;
      seen = bus.curbit_valid;
    end
    check("clear_next_pulse_count", bus.mod_count, 1);
    // threshold vectors
    foreach (vecs[v]) begin
      thr = vecs[v].th;
      for (int i = 0; i < 3 * P; i++) step(1, sq(i, vecs[v].lo_v, vecs[v].hi_v), 0);
      check($sformatf("vec%0d_curbit", v), bus.curbit, vecs[v].exp_cur);
    end
    // single rising step: no falling peak, never modulated
    thr = 40;
    for (int i = 0; i < 3 * P; i++) step(1, 100, 0);
    held = 0;
    for (int i = 0; i < 4 * P; i++) begin
      step(1, 200, 0);
      if (bus.curbit) held++;
    end
    check("one_sided_curbit_highs", held, 0);
    // enable dropped mid-frame
    for (int i = 0; i < 2 * N && phase != 50; i++) step(1, $urandom_range(255), 0);
    held = int'(bus.mod_count);
    step(0, 100, 0);
    check("disable_ssp", {bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.curbit, bus.curbit_valid}, 0);
    check("disable_count_held", bus.mod_count, held);
    step(0, 100, 0);
    edges = 0;
    for (int i = 0; i < 40 && !bus.ssp_frame; i++) begin
      step(1, 100, 0);
      edges++;
    end
    check("reenable_frame_edges", edges, 8);
    // asynchronous reset mid-frame
    for (int i = 0; i < 2 * N && phase != 50; i++) step(1, sq(i, 100, 200), 0);
    rst = 1;
    #2;
    check("async_reset", {bus.curbit, bus.curbit_valid, bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.mod_count}, 0);
    model_reset();
    @(posedge osc_clk);
    #1;
    rst = 0;
    edges = 0;
    for (int i = 0; i < 40 && !bus.ssp_frame; i++) begin
      step(1, 100, 0);
      edges++;
    end
    check("post_reset_frame_edges", edges, 8);
    // random stimulus with occasional disable, clear and phase changes
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) rph = $urandom_range(15);
      if ($urandom_range(99) < 5) thr = $urandom_range(400);
      step($urandom_range(99) >= 3, $urandom_range(255), $urandom_range(99) < 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
